// File: rtl/display_pkg.sv
// Shared constants for the display scan controller: decoder state codes,
// the blank-digit value and the controller FSM encoding.
package display_pkg;

    localparam logic [3:0] ST_NONE     = 4'b0000;
    localparam logic [3:0] ST_TOTAL    = 4'b0110;
    localparam logic [3:0] ST_PARTIAL  = 4'b1101;
    localparam logic [3:0] ST_FAIL     = 4'b1110;
    localparam logic [3:0] BLANK_DIGIT = 4'hF;

    // SCAN   | plain digit multiplexing, status requests accepted
    // STATUS | message held for HOLD_CYCLES, scan keeps running underneath
    typedef enum logic {
        SCAN   = 1'b0,
        STATUS = 1'b1
    } ctrl_state_e;

    function automatic logic is_legal_code(input logic [3:0] code);
        return (code == ST_TOTAL) || (code == ST_PARTIAL) || (code == ST_FAIL);
    endfunction

endpackage

// File: rtl/display_scan_controller_scan_timer.sv
// Refresh divider and digit index counter; frame_start_o marks the first
// cycle of each scan frame (index 0, refresh count 0).
module scan_timer #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         clear_i,
    output logic [(NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1)-1:0] digit_idx_o,
    output logic                                         frame_start_o
);

    localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [REF_W-1:0] REF_MAX = REF_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

    logic [REF_W-1:0] refresh_q, refresh_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    always_comb begin
        refresh_d = refresh_q + 1'b1;
        idx_d     = idx_q;
        if (refresh_q == REF_MAX) begin
            refresh_d = '0;
            idx_d     = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        end
        if (clear_i) begin
            refresh_d = '0;
            idx_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_q <= '0;
            idx_q     <= '0;
        end else begin
            refresh_q <= refresh_d;
            idx_q     <= idx_d;
        end
    end

    assign digit_idx_o   = idx_q;
    assign frame_start_o = (refresh_q == '0) && (idx_q == '0);

endmodule

// File: rtl/display_scan_controller.sv
// Multiplexes BCD digits onto one shared 7-seg decoder and overlays timed
// status messages (failure message blinks) on top of the running scan.
module display_scan_controller
    import display_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int HOLD_CYCLES = 100000000,
    parameter int BLINK_DIV   = 12500000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    status_valid,
    input  logic [3:0]              status_code,
    output logic                    status_ready,
    output logic                    status_active,
    output logic [3:0]              dec_entrada,
    output logic [3:0]              dec_estado,
    output logic [NUM_DIGITS-1:0]   anode
);

    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_DIV - 1);

    ctrl_state_e             state_q, state_d;
    logic [HOLD_W-1:0]       hold_q, hold_d;
    logic [BLINK_W-1:0]      blink_cnt_q, blink_cnt_d;
    logic                    blink_ph_q, blink_ph_d;
    logic [3:0]              code_q, code_d;
    logic [4*NUM_DIGITS-1:0] snap_digits_q, eff_digits;
    logic [NUM_DIGITS-1:0]   snap_en_q, eff_en;
    logic [NUM_DIGITS-1:0]   anode_d;
    logic [3:0]              entrada_d, estado_d;
    logic [IDX_W-1:0]        digit_idx;
    logic                    frame_start, accept, hold_done, timer_clear;

    // Ready is only ever high in SCAN, so no separate state qualifier is needed.
    assign accept      = status_valid && status_ready && is_legal_code(status_code);
    assign hold_done   = (state_q == STATUS) && (hold_q == HOLD_MAX);
    assign timer_clear = accept || hold_done;

    scan_timer #(
        .NUM_DIGITS  (NUM_DIGITS),
        .REFRESH_DIV (REFRESH_DIV)
    ) u_scan_timer (
        .clk           (clk),
        .reset         (reset),
        .clear_i       (timer_clear),
        .digit_idx_o   (digit_idx),
        .frame_start_o (frame_start)
    );

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        blink_cnt_d = blink_cnt_q;
        blink_ph_d  = blink_ph_q;
        code_d      = code_q;
        case (state_q)
            SCAN: begin
                if (accept) begin
                    state_d     = STATUS;
                    hold_d      = '0;
                    blink_cnt_d = '0;
                    blink_ph_d  = 1'b0;
                    code_d      = status_code;
                end
            end
            STATUS: begin
                if (hold_done) begin
                    state_d = SCAN;
                end else begin
                    hold_d      = hold_q + 1'b1;
                    blink_cnt_d = (blink_cnt_q == BLINK_MAX) ? '0 : blink_cnt_q + 1'b1;
                    blink_ph_d  = blink_ph_q ^ (blink_cnt_q == BLINK_MAX);
                end
            end
            default: state_d = SCAN;
        endcase
    end

    // The frame's first slot uses live inputs, which are captured for the rest of the frame.
    always_comb begin
        eff_digits = frame_start ? digits_in : snap_digits_q;
        eff_en     = frame_start ? digit_en : snap_en_q;
        anode_d    = '1;
        entrada_d  = BLANK_DIGIT;
        if (eff_en[digit_idx]) begin
            anode_d[digit_idx] = 1'b0;
            entrada_d          = eff_digits[4*digit_idx +: 4];
        end
        if ((state_d == STATUS) && (code_d == ST_FAIL) && blink_ph_d) begin
            anode_d = '1;
        end
        estado_d = (state_d == STATUS) ? code_d : ST_NONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= SCAN;
            hold_q        <= '0;
            blink_cnt_q   <= '0;
            blink_ph_q    <= 1'b0;
            code_q        <= ST_NONE;
            snap_digits_q <= '0;
            snap_en_q     <= '0;
            anode         <= '1;
            dec_entrada   <= 4'h0;
            dec_estado    <= ST_NONE;
            status_active <= 1'b0;
            status_ready  <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_ph_q    <= blink_ph_d;
            code_q        <= code_d;
            snap_digits_q <= eff_digits;
            snap_en_q     <= eff_en;
            anode         <= anode_d;
            dec_entrada   <= entrada_d;
            dec_estado    <= estado_d;
            status_active <= (state_d == STATUS);
            status_ready  <= (state_d == SCAN);
        end
    end

endmodule
